// File: rtl/reg_read.sv
// reg_read: br32 register-read stage -- architectural register file, per-register
// pending-write scoreboard and registered operand latch. Define REG_READ_BYPASS_EN for WB->read bypass.
module reg_read #(
  parameter int unsigned SB_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic        in_w_rd,
  output logic        stall,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_res,
  input  logic        kill_we,
  input  logic [4:0]  kill_rd,
  output logic [31:0] out_pc,
  output logic [31:0] out_op1,
  output logic [31:0] out_op2,
  output logic [4:0]  out_rd,
  output logic        out_w_rd,
  output logic        out_bubble
);
  localparam int unsigned NREG = 32;
  localparam int unsigned XW   = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned CW   = SB_W + 2;  // holds cnt+1 and up to three decrements
  localparam logic [SB_W-1:0] CNT_MAX = '1;
`ifdef REG_READ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [XW-1:0]   regs_q [NREG];
  logic [XW-1:0]   regs_d [NREG];
  logic [SB_W-1:0] cnt_q  [NREG];
  logic [SB_W-1:0] cnt_d  [NREG];
  logic [NREG-1:0] underflow_c;

  logic [XW-1:0] out_pc_q, out_pc_d, out_op1_q, out_op1_d, out_op2_q, out_op2_d;
  logic [RW-1:0] out_rd_q, out_rd_d;
  logic          out_w_rd_q, out_w_rd_d, out_bubble_q, out_bubble_d;

  logic          hit1, hit2, rdy1, rdy2, rd_full, issue;
  logic [XW-1:0] op1, op2;

  // Source readiness, stall and operand selection
  always_comb begin : src_check
    hit1    = BYPASS && wb_we && (wb_rd == in_rs1) && (in_rs1 != '0);
    hit2    = BYPASS && wb_we && (wb_rd == in_rs2) && (in_rs2 != '0);
    rdy1    = (in_rs1 == '0) || (cnt_q[in_rs1] == '0) || (hit1 && (cnt_q[in_rs1] == SB_W'(1)));
    rdy2    = (in_rs2 == '0) || (cnt_q[in_rs2] == '0) || (hit2 && (cnt_q[in_rs2] == SB_W'(1)));
    rd_full = in_w_rd && (in_rd != '0) && (cnt_q[in_rd] == CNT_MAX);
    stall   = in_valid && (!rdy1 || !rdy2 || rd_full);
    issue   = in_valid && !stall && !flush;
    op1     = hit1 ? wb_res : ((in_rs1 == '0) ? '0 : regs_q[in_rs1]);
    op2     = hit2 ? wb_res : ((in_rs2 == '0) ? '0 : regs_q[in_rs2]);
  end

  // Scoreboard: all increments and decrements of a cycle applied together, floored at 0
  always_comb begin : sb_next
    logic [CW-1:0] up;
    logic [CW-1:0] down;
    for (int r = 0; r < NREG; r++) begin
      up   = CW'(cnt_q[r]) + CW'(issue && in_w_rd && (in_rd == RW'(r)));
      down = CW'(wb_we && (wb_rd == RW'(r)))
           + CW'(kill_we && (kill_rd == RW'(r)))
           + CW'(flush && !out_bubble_q && out_w_rd_q && (out_rd_q == RW'(r)));
      underflow_c[r] = (r != 0) && (down > up);
      if ((r == 0) || (down > up)) cnt_d[r] = '0;
      else                         cnt_d[r] = SB_W'(up - down);
    end
  end

  always_comb begin : rf_next
    regs_d = regs_q;
    if (wb_we && (wb_rd != '0)) regs_d[wb_rd] = wb_res;
  end

  always_comb begin : out_next
    out_pc_d     = out_pc_q;
    out_op1_d    = out_op1_q;
    out_op2_d    = out_op2_q;
    out_rd_d     = out_rd_q;
    out_w_rd_d   = 1'b0;
    out_bubble_d = 1'b1;
    if (issue) begin
      out_pc_d     = in_pc;
      out_op1_d    = op1;
      out_op2_d    = op2;
      out_rd_d     = in_rd;
      out_w_rd_d   = in_w_rd;
      out_bubble_d = 1'b0;
    end
  end

  // Register file has no reset
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      out_pc_q     <= '0;
      out_op1_q    <= '0;
      out_op2_q    <= '0;
      out_rd_q     <= '0;
      out_w_rd_q   <= 1'b0;
      out_bubble_q <= 1'b1;
    end else begin
      a_no_underflow: assert (underflow_c == '0);
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      out_pc_q     <= out_pc_d;
      out_op1_q    <= out_op1_d;
      out_op2_q    <= out_op2_d;
      out_rd_q     <= out_rd_d;
      out_w_rd_q   <= out_w_rd_d;
      out_bubble_q <= out_bubble_d;
    end
  end

  assign out_pc     = out_pc_q;
  assign out_op1    = out_op1_q;
  assign out_op2    = out_op2_q;
  assign out_rd     = out_rd_q;
  assign out_w_rd   = out_w_rd_q;
  assign out_bubble = out_bubble_q;
endmodule

// File: tb/tb_reg_read.sv
// tb_reg_read: directed + randomized bench for reg_read with a queue scoreboard and a rule-level model.
module tb_reg_read;
  localparam int MAXC = 3;
`ifdef REG_READ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_w_rd = 1'b0, flush = 1'b0, wb_we = 1'b0, kill_we = 1'b0;
  logic [31:0] in_pc = '0, wb_res = '0;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0, wb_rd = '0, kill_rd = '0;
  logic        stall, out_w_rd, out_bubble;
  logic [31:0] out_pc, out_op1, out_op2;
  logic [4:0]  out_rd;

  reg_read dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_w_rd(in_w_rd), .stall(stall), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_res(wb_res), .kill_we(kill_we), .kill_rd(kill_rd), .out_pc(out_pc), .out_op1(out_op1),
    .out_op2(out_op2), .out_rd(out_rd), .out_w_rd(out_w_rd), .out_bubble(out_bubble)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        w_rd;
  } exp_t;

  typedef struct {
    bit v; logic [31:0] pc; int rs1; int rs2; int rd; bit w;
    bit fl; bit we; int wrd; logic [31:0] res; bit kw; int krd; bit r;
  } stim_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [31:0] m_regs[32];
  int          m_cnt[32];
  bit          m_out_v = 1'b0, m_out_w = 1'b0;
  int          m_out_rd = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  function automatic stim_t mk(input bit v, input int rs1, input int rs2, input int rd, input bit w);
    stim_t s;
    s = '{default: 0};
    s.v = v; s.pc = $urandom; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.w = w;
    return s;
  endfunction

  // Reference rules: a source is current if x0, nothing pending, or (bypass) its last writer retires now
  function automatic bit m_hit(input stim_t s, input int src);
    return BYP && s.we && (s.wrd == src) && (src != 0);
  endfunction
  function automatic bit m_ready(input stim_t s, input int src);
    return (src == 0) || (m_cnt[src] == 0) || (m_hit(s, src) && m_cnt[src] == 1);
  endfunction
  function automatic logic [31:0] m_opnd(input stim_t s, input int src);
    if (m_hit(s, src)) return s.res;
    if (src == 0) return 32'h0;
    return m_regs[src];
  endfunction

  task automatic step(input stim_t s, input int exp_stall);
    bit ms, iss;
    int d;
    exp_t e;
    rst = s.r; in_valid = s.v; in_pc = s.pc; in_rs1 = 5'(s.rs1); in_rs2 = 5'(s.rs2);
    in_rd = 5'(s.rd); in_w_rd = s.w; flush = s.fl; wb_we = s.we; wb_rd = 5'(s.wrd);
    wb_res = s.res; kill_we = s.kw; kill_rd = 5'(s.krd);
    #1;
    ms = s.v && (!m_ready(s, s.rs1) || !m_ready(s, s.rs2) || (s.w && s.rd != 0 && m_cnt[s.rd] == MAXC));
    chk("stall_model", 128'(stall), 128'(ms));
    if (exp_stall >= 0) chk("stall_directed", 128'(stall), 128'(exp_stall));
    if (s.r) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_out_v = 1'b0; m_out_w = 1'b0; m_out_rd = 0;
    end else begin
      iss = s.v && !ms && !s.fl;
      if (iss) begin
        e = {s.pc, m_opnd(s, s.rs1), m_opnd(s, s.rs2), 5'(s.rd), s.w};
        exp_q.push_back(e);
      end
      for (int r = 1; r < 32; r++) begin
        d = m_cnt[r] + int'(iss && s.w && s.rd == r) - int'(s.we && s.wrd == r)
          - int'(s.kw && s.krd == r) - int'(s.fl && m_out_v && m_out_w && m_out_rd == r);
        m_cnt[r] = (d < 0) ? 0 : d;
      end
      if (s.we && s.wrd != 0) m_regs[s.wrd] = s.res;
      m_out_v = iss; m_out_w = iss && s.w; m_out_rd = s.rd;
    end
    @(negedge clk);
  endtask

  // Monitor: every presented instruction must match the oldest expected issue
  initial begin
    exp_t a, e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        a = {out_pc, out_op1, out_op2, out_rd, out_w_rd};
        if (out_bubble === 1'b0) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_issue actual=%0h required=bubble @%0t", a, $time);
          end else begin
            e = exp_q.pop_front();
            chk("issue_payload", 128'(a), 128'(e));
          end
        end else begin
          chk("bubble_w_rd", 128'(out_w_rd), 128'(0));
        end
      end
    end
  end

  initial begin
    stim_t s, rd;
    int avail[32];
    int t;
    foreach (m_cnt[i]) begin m_cnt[i] = 0; m_regs[i] = '0; end
    repeat (2) @(negedge clk);
    chk("rst_bubble", 128'(out_bubble), 128'(1));
    chk("rst_w_rd", 128'(out_w_rd), 128'(0));
    chk("rst_pc", 128'(out_pc), 128'(0));
    chk("rst_op1", 128'(out_op1), 128'(0));
    chk("rst_op2", 128'(out_op2), 128'(0));
    chk("rst_rd", 128'(out_rd), 128'(0));
    rst = 1'b0;
    mon_en = 1'b1;

    step(mk(1, 0, 0, 5, 1), 0);
    chk("x0_operands", 128'({out_bubble, out_op1, out_op2}), 128'(0));
    s = mk(1, 5, 0, 0, 0); s.we = 1; s.wrd = 5; s.res = 32'hDEADBEEF;
    step(s, BYP ? 0 : 1);
    s.we = 0;
    step(s, 0);
    chk("x5_after_wb", 128'(out_op1), 128'(32'hDEADBEEF));

    // Give every register a known value
    for (int r = 1; r < 32; r++) begin
      s = mk(1, 0, 0, r, 1);
      if (r > 1) begin s.we = 1; s.wrd = r - 1; s.res = $urandom; end
      step(s, 0);
    end
    s = mk(0, 0, 0, 0, 0); s.we = 1; s.wrd = 31; s.res = $urandom;
    step(s, 0);

    // Writer-count saturation on x7, then a reader draining it
    s = mk(1, 0, 0, 7, 1);
    repeat (3) step(s, 0);
    step(s, 1);
    step(s, 1);
    s.we = 1; s.wrd = 7; s.res = $urandom;
    step(s, 1);
    s.we = 0;
    step(s, 0);
    rd = mk(1, 7, 0, 0, 0); rd.we = 1; rd.wrd = 7;
    rd.res = $urandom; step(rd, 1);
    rd.res = $urandom; step(rd, 1);
    rd.res = $urandom; step(rd, BYP ? 0 : 1);
    rd.we = 0;
    step(rd, 0);

    // Flush squashes the x9 writer in the output and suppresses the incoming increment
    step(mk(1, 0, 0, 9, 1), 0);
    s = mk(1, 0, 0, 9, 1); s.fl = 1;
    step(s, 0);
    chk("flush_bubble", 128'(out_bubble), 128'(1));
    step(mk(1, 9, 9, 0, 0), 0);

    // Two decrements and one increment on x3 in the same cycle
    step(mk(1, 0, 0, 3, 1), 0);
    step(mk(1, 0, 0, 3, 1), 0);
    s = mk(1, 0, 0, 3, 1); s.we = 1; s.wrd = 3; s.res = $urandom; s.kw = 1; s.krd = 3;
    step(s, 0);
    rd = mk(1, 3, 0, 0, 0);
    step(rd, 1);
    rd.we = 1; rd.wrd = 3; rd.res = $urandom;
    step(rd, BYP ? 0 : 1);
    rd.we = 0;
    step(rd, 0);

    // Mid-stream reset with pending writers
    step(mk(1, 0, 0, 10, 1), 0);
    step(mk(1, 0, 0, 11, 1), 0);
    s = mk(1, 0, 0, 12, 1); s.r = 1;
    step(s, -1);
    chk("midrst_bubble", 128'(out_bubble), 128'(1));
    chk("midrst_w_rd", 128'(out_w_rd), 128'(0));
    step(mk(1, 10, 11, 0, 0), 0);
    step(mk(1, 12, 12, 0, 0), 0);

    // Randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 600; i++) begin
      s = mk($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      if (i == 300) begin
        s.r = 1;
        step(s, -1);
        continue;
      end
      foreach (avail[j]) avail[j] = m_cnt[j];
      s.fl = ($urandom_range(0, 9) == 0);
      if (s.fl && m_out_v && m_out_w && m_out_rd != 0) begin
        if (avail[m_out_rd] > 0) avail[m_out_rd]--;
        else s.fl = 0;
      end
      if ($urandom_range(0, 9) < 5) begin
        t = $urandom_range(1, 7);
        if (avail[t] > 0) begin s.we = 1; s.wrd = t; s.res = $urandom; avail[t]--; end
      end else if ($urandom_range(0, 19) == 0) begin
        s.we = 1; s.wrd = 0; s.res = $urandom;
      end
      if ($urandom_range(0, 7) == 0) begin
        t = $urandom_range(1, 7);
        if (avail[t] > 0) begin s.kw = 1; s.krd = t; avail[t]--; end
      end
      step(s, -1);
    end

    repeat (3) step(mk(0, 0, 0, 0, 0), -1);
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_read.md
# reg_read

Register-read stage for the br32 pipeline. Owns the 32×32 architectural register file and consumes the writeback stage's write port. Presents registered source operands to execute. A per-register pending-write scoreboard stalls decode until every operand it reads is architecturally current.

## Interface

Parameters:
- `SB_W`, default 2: width of each per-register pending-write counter; max in-flight writers per register is 2^SB_W−1.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: decode presents an instruction this cycle.
- `in_pc` in 32: instruction PC.
- `in_rs1`, `in_rs2` in 5 each: source register indices.
- `in_rd` in 5: destination index.
- `in_w_rd` in 1: instruction writes `in_rd`.
- `stall` out 1: combinational; decode must hold its instruction.
- `flush` in 1: squash the instruction in the output register.
- `wb_we` in 1: writeback write enable, already qualified by WB bubble.
- `wb_rd` in 5: writeback destination.
- `wb_res` in 32: writeback data.
- `kill_we` in 1: a downstream stage squashed an instruction that had `w_rd` set.
- `kill_rd` in 5: destination of the squashed instruction.
- `out_pc` out 32: registered PC.
- `out_op1`, `out_op2` out 32: registered operands.
- `out_rd` out 5: registered destination.
- `out_w_rd` out 1: registered write flag, forced 0 when bubbling.
- `out_bubble` out 1: output register holds no instruction.

## Operation

- Register array `regs[0..31]`:
  - Written on posedge when `wb_we && wb_rd != 0`.
  - `x0` always reads 0 and is never written.
  - The array is not reset.
- Scoreboard `cnt[r]` (SB_W bits, r=1..31) counts issued-but-not-retired writers of `r`. Net update per cycle is inc − dec, all terms applied together:
  - +1 when an instruction issues with `in_w_rd && in_rd != 0`.
  - −1 when `wb_we` targets `r`.
  - −1 when `kill_we` targets `r`.
  - −1 when `flush` squashes a valid output instruction whose `out_w_rd` targets `r`.
  - Up to three decrements may hit the same `r` in one cycle.
  - Decrement below 0 is a protocol error; assert in simulation and hold the counter at 0.
- Source `s` is ready when any of:
  - `s == 0`;
  - `cnt[s] == 0`;
  - `BYPASS_EN` is set, `cnt[s] == 1`, and `wb_we && wb_rd == s` this cycle.
- Ready sources read `wb_res` on a bypass hit, else `regs[s]`.
- `stall = in_valid && (!ready(rs1) || !ready(rs2) || (in_w_rd && in_rd != 0 && cnt[in_rd] == max))`.
- Issue happens when `in_valid && !stall && !flush`. The output register loads pc, operands, rd, w_rd and clears `out_bubble`.
- When not issuing (invalid, stalled, or flush), the output register sets `out_bubble = 1` and `out_w_rd = 0`. Other fields are don't-care.
- `flush` overrides issue in the same cycle. The incoming instruction is not issued, its `cnt` increment is suppressed, and decode re-presents it or drops it.

## Timing

- Issue-to-output latency is 1 cycle. Operands are sampled in the issue cycle.
- WB write and bypass share a cycle. An instruction issuing the same cycle WB writes its source sees the new value:
  - via bypass when `BYPASS_EN` is set;
  - otherwise it stalls that cycle and reads `regs` the next cycle, a 1-cycle penalty.
- `stall` depends combinationally on `cnt`, `wb_we`/`wb_rd` and the `in_*` inputs only. It never depends on `flush`.
- Reset values:
  - all `cnt` = 0;
  - `out_bubble` = 1, `out_w_rd` = 0;
  - `out_pc`, `out_op1`, `out_op2` = 0; `out_rd` = 0.
- Reset mid-operation wins over every other event in that cycle.
- Downstream stages must drop in-flight instructions on the same reset, so no WB write after reset refers to a pre-reset issue.

## Configuration

- `REG_READ_BYPASS_EN` defined: WB→read write-through bypass as described above.
- Not defined: a source is ready only when `cnt[s] == 0`. `stall` loses its dependence on `wb_*`, and a back-to-back dependency costs one extra cycle.

## Test plan

- Reset, then issue an instruction reading x0,x0 writing x5 → next cycle `out_op1 = out_op2 = 0`, `out_bubble = 0`, `cnt[5] = 1`.
- With `cnt[5] = 1`, issue a reader of x5 in the same cycle as `wb_we`, `wb_rd = 5`, `wb_res = 0xDEADBEEF`:
  - with bypass → no stall, `out_op1 = 0xDEADBEEF`;
  - without bypass → 1-cycle stall, then the same value.
- Issue three writers of x7 back-to-back, then a fourth while `cnt[7] = 3` → `stall = 1` until a WB write to x7. A reader of x7 stalls until `cnt[7]` reaches 0, or 1 with a bypass hit.
- Hold `flush` while the output holds a writer of x9 and decode presents a writer of x9 → `cnt[9]` decreases by 1, the next `out_bubble = 1`, and there is no increment.
- Same-cycle `wb_we` x3, `kill_we` x3, and an issue writing x3 with `cnt[3] = 2` → `cnt[3] = 1`.
- Assert `rst` for 1 cycle mid-stream with pending counts → all counts 0, `out_bubble = 1`, and a reader of any register issues without stall.
